// File: rtl/otter_dmem_arbiter_if.sv
// Request/response bundle between one data-memory master and the arbiter.
// The master drives the command and holds req until it sees gnt.
interface otter_dmem_arbiter_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wd;
  logic [1:0]  size;
  logic        sign;
  logic        gnt;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, we, addr, wd, size, sign, input gnt, ack, rdata);
  modport slave  (input req, we, addr, wd, size, sign, output gnt, ack, rdata);
endinterface

// File: rtl/otter_dmem_arbiter.sv
// Shares the OTTER data-memory port between the CPU load/store unit (m0) and the
// SimonSays engine (m1). Exactly one access is in flight at a time.
module otter_dmem_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic                CLK,
  input  logic                RST,
  otter_dmem_arbiter_if.slave m0,
  otter_dmem_arbiter_if.slave m1,
  output logic                MEM_RDEN2,
  output logic                MEM_WE2,
  output logic [31:0]         MEM_ADDR2,
  output logic [31:0]         MEM_WD,
  output logic [1:0]          MEM_SIZE,
  output logic                MEM_SIGN,
  input  logic [31:0]         MEM_DOUT2
);
  typedef enum logic [1:0] {IDLE, WR, RD_ISSUE, RD_DATA} state_t;

  state_t      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;  // most recently granted master, 1 = m1
  logic [31:0] addr_q, addr_d;
  logic [31:0] wd_q, wd_d;
  logic [1:0]  size_q, size_d;
  logic        sign_q, sign_d;
  logic [1:0]  gnt_q, gnt_d;
  logic [1:0]  ack_q, ack_d;
  logic [31:0] rdata_q [2];
  logic [31:0] rdata_d [2];

  logic [1:0]  req;
  logic [1:0]  req_we;
  logic [1:0]  req_sign;
  logic [31:0] req_addr [2];
  logic [31:0] req_wd [2];
  logic [1:0]  req_size [2];
  logic        sel;

  assign req         = {m1.req, m0.req};
  assign req_we      = {m1.we, m0.we};
  assign req_sign    = {m1.sign, m0.sign};
  assign req_addr[0] = m0.addr;
  assign req_addr[1] = m1.addr;
  assign req_wd[0]   = m0.wd;
  assign req_wd[1]   = m1.wd;
  assign req_size[0] = m0.size;
  assign req_size[1] = m1.size;

  // m1 wins when alone, or on a tie when round-robin says m0 went last
  assign sel = req[1] & (~req[0] | (RR_EN & ~last_q));

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    addr_d  = addr_q;
    wd_d    = wd_q;
    size_d  = size_q;
    sign_d  = sign_q;
    gnt_d   = 2'b00;
    ack_d   = 2'b00;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          gnt_d[sel] = 1'b1;
          owner_d    = sel;
          last_d     = sel;
          addr_d     = req_addr[sel];
          wd_d       = req_wd[sel];
          size_d     = req_size[sel];
          sign_d     = req_sign[sel];
          state_d    = req_we[sel] ? WR : RD_ISSUE;
        end
      end
      WR: begin
        ack_d[owner_q] = 1'b1;
        state_d        = IDLE;
      end
      RD_ISSUE: state_d = RD_DATA;
      RD_DATA: begin
        rdata_d[owner_q] = MEM_DOUT2;
        ack_d[owner_q]   = 1'b1;
        state_d          = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      addr_q     <= '0;
      wd_q       <= '0;
      size_q     <= '0;
      sign_q     <= 1'b0;
      gnt_q      <= '0;
      ack_q      <= '0;
      rdata_q[0] <= '0;
      rdata_q[1] <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      addr_q  <= addr_d;
      wd_q    <= wd_d;
      size_q  <= size_d;
      sign_q  <= sign_d;
      gnt_q   <= gnt_d;
      ack_q   <= ack_d;
      rdata_q <= rdata_d;
    end
  end

  // Strobes are gated by reset so an aborted access never touches memory
  assign MEM_RDEN2 = (state_q == RD_ISSUE) & ~RST;
  assign MEM_WE2   = (state_q == WR) & ~RST;
  assign MEM_ADDR2 = addr_q;
  assign MEM_WD    = wd_q;
  assign MEM_SIZE  = size_q;
  assign MEM_SIGN  = sign_q;

  assign m0.gnt   = gnt_q[0];
  assign m0.ack   = ack_q[0];
  assign m0.rdata = rdata_q[0];
  assign m1.gnt   = gnt_q[1];
  assign m1.ack   = ack_q[1];
  assign m1.rdata = rdata_q[1];
endmodule

// File: tb/tb_otter_dmem_arbiter.sv
// Bench for otter_dmem_arbiter: directed steps plus random traffic, checked against
// a byte-addressed reference memory and the arbitration rule.
module tb_otter_dmem_arbiter;
  logic CLK = 1'b0;
  logic RST;
  always #5 CLK = ~CLK;

  otter_dmem_arbiter_if m0_if ();
  otter_dmem_arbiter_if m1_if ();
  otter_dmem_arbiter_if f0_if ();
  otter_dmem_arbiter_if f1_if ();

  logic        mem_rden2, mem_we2, mem_sign;
  logic [31:0] mem_addr2, mem_wd, mem_dout2;
  logic [1:0]  mem_size;
  logic        f_rden2, f_we2, f_sign;
  logic [31:0] f_addr2, f_wd;
  logic [1:0]  f_size;

  otter_dmem_arbiter #(.RR_EN(1'b1)) dut (
    .CLK(CLK), .RST(RST), .m0(m0_if), .m1(m1_if),
    .MEM_RDEN2(mem_rden2), .MEM_WE2(mem_we2), .MEM_ADDR2(mem_addr2), .MEM_WD(mem_wd),
    .MEM_SIZE(mem_size), .MEM_SIGN(mem_sign), .MEM_DOUT2(mem_dout2)
  );

  otter_dmem_arbiter #(.RR_EN(1'b0)) dut_fp (
    .CLK(CLK), .RST(RST), .m0(f0_if), .m1(f1_if),
    .MEM_RDEN2(f_rden2), .MEM_WE2(f_we2), .MEM_ADDR2(f_addr2), .MEM_WD(f_wd),
    .MEM_SIZE(f_size), .MEM_SIGN(f_sign), .MEM_DOUT2(32'h0)
  );

  // The fixed-priority instance sees exactly the same requests
  assign f0_if.req = m0_if.req;  assign f1_if.req = m1_if.req;
  assign f0_if.we = m0_if.we;    assign f1_if.we = m1_if.we;
  assign f0_if.addr = m0_if.addr; assign f1_if.addr = m1_if.addr;
  assign f0_if.wd = m0_if.wd;    assign f1_if.wd = m1_if.wd;
  assign f0_if.size = m0_if.size; assign f1_if.size = m1_if.size;
  assign f0_if.sign = m0_if.sign; assign f1_if.sign = m1_if.sign;

  // Memory: word array, 1-cycle registered read, combinational sizing on held address
  logic [31:0] mem_w [0:1023];
  logic [31:0] io_in;
  logic [31:0] rd_word, rd_sh, wd_sh;
  logic [3:0]  lane_en;

  always_comb begin
    rd_sh = rd_word >> {mem_addr2[1:0], 3'b000};
    case (mem_size)
      2'd0:    mem_dout2 = mem_sign ? {24'h0, rd_sh[7:0]} : {{24{rd_sh[7]}}, rd_sh[7:0]};
      2'd1:    mem_dout2 = mem_sign ? {16'h0, rd_sh[15:0]} : {{16{rd_sh[15]}}, rd_sh[15:0]};
      default: mem_dout2 = rd_word;
    endcase
  end

  always_comb begin
    wd_sh   = mem_wd << {mem_addr2[1:0], 3'b000};
    lane_en = 4'b0000;
    for (int j = 0; j < 4; j++) begin
      lane_en[j] = (mem_size == 2'd2) ||
                   (mem_size == 2'd1 && 1'(j >> 1) == mem_addr2[1]) ||
                   (mem_size == 2'd0 && 2'(j) == mem_addr2[1:0]);
    end
  end

  always @(posedge CLK) begin
    if (mem_rden2) rd_word <= (mem_addr2 >= 32'h10000) ? io_in : mem_w[mem_addr2[11:2]];
    if (mem_we2 && mem_addr2 < 32'h10000) begin
      for (int j = 0; j < 4; j++)
        if (lane_en[j]) mem_w[mem_addr2[11:2]][8*j +: 8] <= wd_sh[8*j +: 8];
    end
  end

  typedef struct {
    bit          we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [1:0]  size;
    bit          sign;
  } cmd_t;

  cmd_t       cur [2];
  logic [7:0] ref_b [0:4095];
  int         last_m;
  int         checks = 0;
  int         errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic cmd_t mk(input bit we, input logic [31:0] addr, input logic [31:0] wd,
                              input logic [1:0] size, input bit sign);
    cmd_t c;
    c.we = we; c.addr = addr; c.wd = wd; c.size = size; c.sign = sign;
    return c;
  endfunction

  function automatic logic [1:0] gnts();
    return {m1_if.gnt, m0_if.gnt};
  endfunction

  function automatic logic [1:0] acks();
    return {m1_if.ack, m0_if.ack};
  endfunction

  function automatic logic [31:0] rdata(input int m);
    return (m == 0) ? m0_if.rdata : m1_if.rdata;
  endfunction

  function automatic logic [31:0] ref_load(input cmd_t c);
    int          n;
    logic [31:0] v, top;
    if (c.addr >= 32'h10000) return io_in;
    n = 1 << c.size;
    v = 0;
    for (int k = 0; k < n; k++) v = v | (32'(ref_b[c.addr[11:0] + 12'(k)]) << (8 * k));
    if (!c.sign && n < 4) begin
      top = 32'h1 << (8 * n - 1);
      if ((v & top) != 0) v = v | ~((top << 1) - 1);
    end
    return v;
  endfunction

  task automatic ref_store(input cmd_t c);
    if (c.addr < 32'h10000)
      for (int k = 0; k < (1 << c.size); k++) ref_b[c.addr[11:0] + 12'(k)] = c.wd[8*k +: 8];
  endtask

  task automatic start(input int m, input cmd_t c);
    cur[m] = c;
    if (m == 0) begin
      m0_if.we = c.we; m0_if.addr = c.addr; m0_if.wd = c.wd;
      m0_if.size = c.size; m0_if.sign = c.sign; m0_if.req = 1'b1;
    end else begin
      m1_if.we = c.we; m1_if.addr = c.addr; m1_if.wd = c.wd;
      m1_if.size = c.size; m1_if.sign = c.sign; m1_if.req = 1'b1;
    end
  endtask

  task automatic drop(input int m);
    if (m == 0) m0_if.req = 1'b0;
    else m1_if.req = 1'b0;
  endtask

  // Called in a cycle where the arbiter is idle and master w is the expected winner
  task automatic serve(input int w);
    cmd_t       c;
    logic [1:0] onehot;
    c = cur[w];
    onehot = 2'(1 << w);
    step();
    chk("gnt", 32'(gnts()), 32'(onehot));
    chk("addr_issue", mem_addr2, c.addr);
    chk("strobe_issue", 32'({mem_rden2, mem_we2}), c.we ? 32'h1 : 32'h2);
    chk("size_sign_issue", 32'({mem_size, mem_sign}), 32'({c.size, c.sign}));
    if (c.we) chk("wd_issue", mem_wd, c.wd);
    drop(w);
    step();
    if (c.we) begin
      chk("store_ack", 32'(acks()), 32'(onehot));
      ref_store(c);
      $display("txn m%0d store addr=%h wd=%h size=%0d", w, c.addr, c.wd, c.size);
    end else begin
      chk("rd_data_quiet", 32'({acks(), mem_rden2, mem_we2}), 32'h0);
      chk("addr_held", mem_addr2, c.addr);
      step();
      chk("load_ack", 32'(acks()), 32'(onehot));
      chk("load_rdata", rdata(w), ref_load(c));
      $display("txn m%0d load  addr=%h rdata=%h size=%0d sign=%0d", w, c.addr, rdata(w), c.size, c.sign);
    end
    last_m = w;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    m0_if.req = 1'b0;
    m1_if.req = 1'b0;
    step();
    step();
    RST = 1'b0;
    last_m = 1;
  endtask

  function automatic cmd_t rand_cmd();
    cmd_t c;
    c.we   = 1'($urandom_range(0, 1));
    c.size = 2'($urandom_range(0, 2));
    c.addr = 32'($urandom_range(0, 15)) << 2;
    if (c.size == 2'd0) c.addr = c.addr + 32'($urandom_range(0, 3));
    if (c.size == 2'd1) c.addr = c.addr + 32'(2 * $urandom_range(0, 1));
    c.wd   = $urandom;
    c.sign = 1'($urandom_range(0, 1));
    return c;
  endfunction

  initial begin
    cmd_t ca, cb;
    int   r, w;
    for (int i = 0; i < 1024; i++) mem_w[i] = 32'h0;
    for (int i = 0; i < 4096; i++) ref_b[i] = 8'h0;
    io_in = 32'h0;
    start(0, mk(1'b0, 32'h0, 32'h0, 2'd0, 1'b0));
    start(1, mk(1'b0, 32'h0, 32'h0, 2'd0, 1'b0));

    // Reset state
    do_reset();
    RST = 1'b1;
    step();
    chk("rst_gnt_ack", 32'({gnts(), acks()}), 32'h0);
    chk("rst_strobes", 32'({mem_rden2, mem_we2}), 32'h0);
    chk("rst_addr", mem_addr2, 32'h0);
    chk("rst_wd_size_sign", mem_wd | 32'({mem_size, mem_sign}), 32'h0);
    chk("rst_rdata", m0_if.rdata | m1_if.rdata, 32'h0);
    RST = 1'b0;
    last_m = 1;

    // Store then load a word
    start(0, mk(1'b1, 32'h100, 32'hDEADBEEF, 2'd2, 1'b0));
    serve(0);
    start(0, mk(1'b0, 32'h100, 32'h0, 2'd2, 1'b0));
    serve(0);
    chk("lw_const", m0_if.rdata, 32'hDEADBEEF);

    // Signed and unsigned byte load of the top byte
    start(0, mk(1'b1, 32'h100, 32'h80000000, 2'd2, 1'b0));
    serve(0);
    start(0, mk(1'b0, 32'h103, 32'h0, 2'd0, 1'b0));
    serve(0);
    chk("lb_const", m0_if.rdata, 32'hFFFFFF80);
    start(0, mk(1'b0, 32'h103, 32'h0, 2'd0, 1'b1));
    serve(0);
    chk("lbu_const", m0_if.rdata, 32'h00000080);

    // Back-to-back stores: re-request in the ack cycle
    start(0, mk(1'b1, 32'h600, 32'hA5A5A5A5, 2'd2, 1'b0));
    serve(0);
    start(0, mk(1'b1, 32'h604, 32'h5A5A5A5A, 2'd2, 1'b0));
    chk("b2b_gap_we", 32'(mem_we2), 32'h0);
    serve(0);
    start(0, mk(1'b0, 32'h604, 32'h0, 2'd2, 1'b0));
    serve(0);
    chk("b2b_readback", m0_if.rdata, 32'h5A5A5A5A);

    // MMIO load from m1
    io_in = 32'h5A;
    start(1, mk(1'b0, 32'h11000, 32'h0, 2'd2, 1'b0));
    serve(1);
    chk("mmio_const", m1_if.rdata, 32'h0000005A);

    // Reset during the read-data cycle
    start(0, mk(1'b0, 32'h100, 32'h0, 2'd2, 1'b0));
    step();
    drop(0);
    step();
    RST = 1'b1;
    #1;
    chk("rst_rd_strobes", 32'({mem_rden2, mem_we2}), 32'h0);
    step();
    RST = 1'b0;
    last_m = 1;
    chk("rst_rd_noack", 32'({gnts(), acks()}), 32'h0);
    chk("rst_rd_rdata", m0_if.rdata, 32'h0);
    chk("rst_rd_addr", mem_addr2, 32'h0);

    // Reset during the write cycle: memory must keep the old word
    start(0, mk(1'b1, 32'h100, 32'h12345678, 2'd2, 1'b0));
    step();
    drop(0);
    RST = 1'b1;
    #1;
    chk("rst_wr_we", 32'(mem_we2), 32'h0);
    step();
    RST = 1'b0;
    last_m = 1;
    chk("rst_wr_noack", 32'({gnts(), acks()}), 32'h0);
    start(0, mk(1'b0, 32'h100, 32'h0, 2'd2, 1'b0));
    serve(0);
    chk("rst_wr_unchanged", m0_if.rdata, 32'h80000000);

    // Continuous contention: round-robin alternates, fixed priority starves m1
    do_reset();
    ca = mk(1'b1, 32'h200, 32'h11111111, 2'd2, 1'b0);
    cb = mk(1'b1, 32'h204, 32'h22222222, 2'd2, 1'b0);
    start(0, ca);
    start(1, cb);
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i % 2 == 1) begin
        w = ((i - 1) / 2) % 2;
        chk("rr_gnt", 32'(gnts()), 32'(1 << w));
        chk("fp_gnt", 32'({f1_if.gnt, f0_if.gnt}), 32'h1);
        chk("fp_we", 32'({f_rden2, f_we2, f_size, f_sign}), 32'b01100);
        chk("fp_addr_wd", f_addr2 ^ f_wd, ca.addr ^ ca.wd);
      end else begin
        w = ((i - 2) / 2) % 2;
        chk("rr_ack", 32'(acks()), 32'(1 << w));
        chk("fp_ack", 32'({f1_if.ack, f0_if.ack}), 32'h1);
        chk("fp_rdata", f0_if.rdata | f1_if.rdata, 32'h0);
      end
      if (i == 8) begin
        drop(0);
        drop(1);
      end
    end
    ref_store(ca);
    ref_store(cb);
    last_m = 1;
    step();
    chk("rr_idle", 32'(gnts()), 32'h0);

    // Random traffic, single and simultaneous requests
    for (int t = 0; t < 40; t++) begin
      r = $urandom_range(1, 3);
      if (r[0]) start(0, rand_cmd());
      if (r[1]) start(1, rand_cmd());
      if (r == 3) begin
        w = (last_m == 0) ? 1 : 0;
        serve(w);
        serve(1 - w);
      end else begin
        serve(r[1] ? 1 : 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
